// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of the 5-stage pipeline. Owns the PC register,
// presents it to instruction memory (combinational read), and captures the
// returned word into the IF/ID pipeline register for decode. Reacts to hazard
// stalls/flushes, downstream branch redirects and halt requests, and keeps
// saturating fetch/bubble counters for performance debug.
//
// Handshake: there is no valid/ready pair on this block. Every input is a
// level request sampled on each rising edge of clk. id_valid qualifies the
// IF/ID contents; when it is low the other id_* outputs carry a bubble
// (id_pc = 0, id_pc_plus4 = 0, id_instruction = NOP_INSTR).
//
// Ports:
//   clk             clock, all state updates on the rising edge
//   rst             asynchronous, active-low reset
//   stall_if        hold PC and IF/ID this cycle
//   flush_id        replace IF/ID with a bubble this cycle
//   redirect_valid  taken branch resolved; load redirect_pc
//   redirect_pc     branch target (low two bits dropped, flagged if set)
//   halt_req        stop fetching (enter HALT)
//   imem_addr       current PC to instruction memory
//   imem_instr      instruction at imem_addr, same cycle
//   id_valid        IF/ID holds a real instruction
//   id_pc           PC of the IF/ID instruction
//   id_pc_plus4     id_pc + 4 (link value for BL)
//   id_instruction  instruction word to decode
//   misalign_err    sticky flag: a redirect target was not word aligned
//   fetch_count     saturating count of real instructions captured
//   bubble_count    saturating count of bubbles inserted (RUN/redirect only)
//   fsm_state       debug view of the fetch FSM state (0 BOOT, 1 RUN, 2 HALT)
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'hD503201F,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_if,
    input  logic             flush_id,
    input  logic             redirect_valid,
    input  logic [63:0]      redirect_pc,
    input  logic             halt_req,
    output logic [63:0]      imem_addr,
    input  logic [31:0]      imem_instr,
    output logic             id_valid,
    output logic [63:0]      id_pc,
    output logic [63:0]      id_pc_plus4,
    output logic [31:0]      id_instruction,
    output logic             misalign_err,
    output logic [CNT_W-1:0] fetch_count,
    output logic [CNT_W-1:0] bubble_count,
    output logic [1:0]       fsm_state
);

    // -------------------------------------------------------------------------
    // Types
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2
    } pc_sel_t;

    // IF/ID register update selection
    typedef enum logic [1:0] {
        ID_HOLD    = 2'd0,
        ID_BUBBLE  = 2'd1,
        ID_CAPTURE = 2'd2
    } id_sel_t;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t          state_q;
    state_t          state_d;
    logic [63:0]     pc_q;
    logic [63:0]     pc_plus4;
    logic [63:0]     redirect_target;
    logic            redirect_misaligned;

    // Control decoded from state + requests
    pc_sel_t         pc_sel;
    id_sel_t         id_sel;
    logic            bump_fetch;
    logic            bump_bubble;
    logic            set_misalign;

    // 64-bit modulo increment; the PC wraps past all-ones silently.
    assign pc_plus4            = pc_q + 64'd4;
    assign redirect_target     = {redirect_pc[63:2], 2'b00};
    assign redirect_misaligned = |redirect_pc[1:0];

    assign imem_addr = pc_q;
    assign fsm_state = state_q;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: begin
                // Boot lasts exactly one cycle regardless of requests.
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    state_d = ST_RUN;
                end else if (halt_req) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                // Only a redirect restarts fetch.
                if (redirect_valid) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: output (control) logic
    //
    // RUN priority: redirect > halt > stall > flush > normal fetch.
    // Stall beats flush so a frozen IF/ID is never clobbered by a bubble
    // while decode is also stalled.
    // -------------------------------------------------------------------------
    always_comb begin
        pc_sel       = PC_HOLD;
        id_sel       = ID_HOLD;
        bump_fetch   = 1'b0;
        bump_bubble  = 1'b0;
        set_misalign = 1'b0;

        case (state_q)
            ST_BOOT: begin
                // IF/ID is loaded with a bubble that is not counted.
                id_sel = ID_BUBBLE;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    pc_sel       = PC_REDIR;
                    id_sel       = ID_BUBBLE;
                    bump_bubble  = 1'b1;
                    set_misalign = redirect_misaligned;
                end else if (halt_req) begin
                    id_sel      = ID_BUBBLE;
                    bump_bubble = 1'b1;
                end else if (stall_if) begin
                    pc_sel = PC_HOLD;
                    id_sel = ID_HOLD;
                end else if (flush_id) begin
                    pc_sel      = PC_INC;
                    id_sel      = ID_BUBBLE;
                    bump_bubble = 1'b1;
                end else begin
                    pc_sel     = PC_INC;
                    id_sel     = ID_CAPTURE;
                    bump_fetch = 1'b1;
                end
            end
            ST_HALT: begin
                id_sel = ID_BUBBLE;
                if (redirect_valid) begin
                    // Leaving HALT behaves exactly like a RUN-state redirect.
                    pc_sel       = PC_REDIR;
                    bump_bubble  = 1'b1;
                    set_misalign = redirect_misaligned;
                end
            end
            default: begin
                id_sel = ID_BUBBLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // PC register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            case (pc_sel)
                PC_INC:   pc_q <= pc_plus4;
                PC_REDIR: pc_q <= redirect_target;
                default:  pc_q <= pc_q;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // IF/ID pipeline register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid       <= 1'b0;
            id_pc          <= 64'd0;
            id_pc_plus4    <= 64'd0;
            id_instruction <= NOP_INSTR;
        end else begin
            case (id_sel)
                ID_BUBBLE: begin
                    id_valid       <= 1'b0;
                    id_pc          <= 64'd0;
                    id_pc_plus4    <= 64'd0;
                    id_instruction <= NOP_INSTR;
                end
                ID_CAPTURE: begin
                    id_valid       <= 1'b1;
                    id_pc          <= pc_q;
                    id_pc_plus4    <= pc_plus4;
                    id_instruction <= imem_instr;
                end
                default: begin
                    id_valid       <= id_valid;
                    id_pc          <= id_pc;
                    id_pc_plus4    <= id_pc_plus4;
                    id_instruction <= id_instruction;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Sticky misalignment flag; cleared only by reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_err <= 1'b0;
        end else if (set_misalign) begin
            misalign_err <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Saturating performance counters: stop at all-ones, never wrap.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count <= '0;
        end else if (bump_fetch && (fetch_count != {CNT_W{1'b1}})) begin
            fetch_count <= fetch_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_count <= '0;
        end else if (bump_bubble && (bubble_count != {CNT_W{1'b1}})) begin
            bubble_count <= bubble_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hD503201F;
  localparam int W = 290;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        stall_if;
  logic        flush_id;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt_req;

  // Main instance (CNT_W = 32)
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [63:0] id_pc_plus4;
  logic [31:0] id_instruction;
  logic        misalign_err;
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
  logic [1:0]  fsm_state;

  // Narrow-counter instance (CNT_W = 4), same stimulus
  logic [63:0] imem_addr_4;
  logic [31:0] imem_instr_4;
  logic        id_valid_4;
  logic [63:0] id_pc_4;
  logic [63:0] id_pc_plus4_4;
  logic [31:0] id_instruction_4;
  logic        misalign_err_4;
  logic [3:0]  fetch_count_4;
  logic [3:0]  bubble_count_4;
  logic [1:0]  fsm_state_4;

  function automatic logic [31:0] imem_fn(input logic [63:0] a);
    if (a == 64'd0) return 32'h91000421;
    if (a == 64'd4) return 32'h8B020020;
    return a[31:0] ^ a[63:32] ^ 32'h5A5A0F0F;
  endfunction

  assign imem_instr   = imem_fn(imem_addr);
  assign imem_instr_4 = imem_fn(imem_addr_4);

  fetch_stage u_dut (
    .clk(clk), .rst(rst), .stall_if(stall_if), .flush_id(flush_id),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .id_instruction(id_instruction), .misalign_err(misalign_err),
    .fetch_count(fetch_count), .bubble_count(bubble_count),
    .fsm_state(fsm_state)
  );

  fetch_stage #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .stall_if(stall_if), .flush_id(flush_id),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt_req(halt_req), .imem_addr(imem_addr_4), .imem_instr(imem_instr_4),
    .id_valid(id_valid_4), .id_pc(id_pc_4), .id_pc_plus4(id_pc_plus4_4),
    .id_instruction(id_instruction_4), .misalign_err(misalign_err_4),
    .fetch_count(fetch_count_4), .bubble_count(bubble_count_4),
    .fsm_state(fsm_state_4)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model of the fetch stage, state 0 BOOT / 1 RUN / 2 HALT
  int          m_state;
  logic [63:0] m_pc;
  logic        m_valid;
  logic [63:0] m_id_pc;
  logic [63:0] m_id_pc4;
  logic [31:0] m_instr;
  logic        m_mis;
  logic [31:0] m_fc;
  logic [31:0] m_bc;

  task automatic model_bubble();
    m_valid  = 1'b0;
    m_id_pc  = 64'd0;
    m_id_pc4 = 64'd0;
    m_instr  = NOP;
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = 64'd0;
    model_bubble();
    m_mis = 1'b0;
    m_fc  = 32'd0;
    m_bc  = 32'd0;
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_redirect(input logic [63:0] rp);
    m_pc = {rp[63:2], 2'b00};
    model_bubble();
    m_bc = sat_inc(m_bc);
    if (rp[1:0] != 2'b00) m_mis = 1'b1;
  endtask

  task automatic model_step(input logic st, input logic fl, input logic rv,
                            input logic [63:0] rp, input logic hr);
    logic [31:0] word;
    word = imem_fn(m_pc);
    case (m_state)
      0: begin
        model_bubble();
        m_state = 1;
      end
      1: begin
        if (rv) begin
          model_redirect(rp);
        end else if (hr) begin
          model_bubble();
          m_bc = sat_inc(m_bc);
          m_state = 2;
        end else if (st) begin
          // everything holds
        end else if (fl) begin
          model_bubble();
          m_bc = sat_inc(m_bc);
          m_pc = m_pc + 64'd4;
        end else begin
          m_valid  = 1'b1;
          m_id_pc  = m_pc;
          m_id_pc4 = m_pc + 64'd4;
          m_instr  = word;
          m_fc     = sat_inc(m_fc);
          m_pc     = m_pc + 64'd4;
        end
      end
      default: begin
        model_bubble();
        if (rv) begin
          model_redirect(rp);
          m_state = 1;
        end
      end
    endcase
    exp_q.push_back({m_pc, m_valid, m_id_pc, m_id_pc4, m_instr, m_mis, m_fc, m_bc});
  endtask

  task automatic compare_out();
    logic [W-1:0] e;
    logic [31:0]  e_fc;
    logic [31:0]  e_bc;
    check("exp_q_depth", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      e_fc = e[63:32];
      e_bc = e[31:0];
      check("imem_addr", imem_addr, e[289:226]);
      check("id_valid", 64'(id_valid), 64'(e[225]));
      check("id_pc", id_pc, e[224:161]);
      check("id_pc_plus4", id_pc_plus4, e[160:97]);
      check("id_instruction", 64'(id_instruction), 64'(e[96:65]));
      check("misalign_err", 64'(misalign_err), 64'(e[64]));
      check("fetch_count", 64'(fetch_count), 64'(e_fc));
      check("bubble_count", 64'(bubble_count), 64'(e_bc));
      check("fetch_count_4", 64'(fetch_count_4), (e_fc > 32'd15) ? 64'd15 : 64'(e_fc));
      check("bubble_count_4", 64'(bubble_count_4), (e_bc > 32'd15) ? 64'd15 : 64'(e_bc));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a falling edge, return at the next falling edge)
  // ---------------------------------------------------------------------------
  task automatic step(input logic st, input logic fl, input logic rv,
                      input logic [63:0] rp, input logic hr);
    stall_if       = st;
    flush_id       = fl;
    redirect_valid = rv;
    redirect_pc    = rp;
    halt_req       = hr;
    model_step(st, fl, rv, rp, hr);
    @(posedge clk);
    #1;
    compare_out();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] bc_before;
    logic [63:0] rnd_pc;

    rst            = 1'b0;
    stall_if       = 1'b0;
    flush_id       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    halt_req       = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    check("rst_imem_addr", imem_addr, 64'd0);
    check("rst_id_valid", 64'(id_valid), 64'd0);
    check("rst_id_instr", 64'(id_instruction), 64'(NOP));
    check("rst_id_pc", id_pc, 64'd0);
    check("rst_fetch_count", 64'(fetch_count), 64'd0);
    check("rst_bubble_count", 64'(bubble_count), 64'd0);
    check("rst_misalign", 64'(misalign_err), 64'd0);

    // Boot, then two real fetches
    rst = 1'b1;
    idle(1);
    check("boot_bubble", 64'(id_valid), 64'd0);
    idle(1);
    check("first_id_pc", id_pc, 64'd0);
    check("first_instr", 64'(id_instruction), 64'h91000421);
    check("first_valid", 64'(id_valid), 64'd1);
    idle(1);
    check("second_id_pc", id_pc, 64'd4);
    check("second_instr", 64'(id_instruction), 64'h8B020020);
    check("two_fetches", 64'(fetch_count), 64'd2);
    check("no_bubbles", 64'(bubble_count), 64'd0);

    // Stall three cycles at pc=8 (flush ignored under stall)
    step(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 64'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
    check("stall_addr", imem_addr, 64'd8);
    check("stall_frozen_pc", id_pc, 64'd4);
    idle(1);
    check("after_stall_pc", id_pc, 64'd8);
    check("after_stall_fc", 64'(fetch_count), 64'd3);

    // Redirect beats stall
    step(1'b1, 1'b0, 1'b1, 64'h40, 1'b0);
    check("redir_addr", imem_addr, 64'h40);
    check("redir_bubble", 64'(id_valid), 64'd0);
    check("redir_bc", 64'(bubble_count), 64'd1);
    idle(1);
    check("redir_id_pc", id_pc, 64'h40);

    // Misaligned redirect target; sticky flag
    step(1'b0, 1'b0, 1'b1, 64'h43, 1'b0);
    check("mis_addr", imem_addr, 64'h40);
    check("mis_set", 64'(misalign_err), 64'd1);
    idle(10);
    check("mis_sticky", 64'(misalign_err), 64'd1);

    // Halt at pc=0x10, requests ignored while halted, then resume at 0
    step(1'b0, 1'b0, 1'b1, 64'h10, 1'b0);
    bc_before = bubble_count;
    step(1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
    for (int i = 0; i < 20; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 64'd0,
           1'($urandom_range(0, 1)));
    check("halt_addr", imem_addr, 64'h10);
    check("halt_bc", 64'(bubble_count), 64'(bc_before + 32'd1));
    check("halt_valid", 64'(id_valid), 64'd0);
    step(1'b0, 1'b0, 1'b1, 64'd0, 1'b0);
    idle(1);
    check("resume_id_pc", id_pc, 64'd0);
    check("resume_valid", 64'(id_valid), 64'd1);

    // Random mix
    for (int i = 0; i < 300; i++) begin
      rnd_pc = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) != 0) rnd_pc[1:0] = 2'b00;
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 15) == 0), rnd_pc, ($urandom_range(0, 31) == 0));
    end

    // PC wrap at 2^64
    step(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    idle(1);
    check("wrap_addr", imem_addr, 64'd0);
    check("wrap_id_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_id_pc4", id_pc_plus4, 64'd0);
    idle(1);
    check("wrap_next_id_pc", id_pc, 64'd0);

    // Narrow counters saturate
    idle(20);
    check("fc4_saturated", 64'(fetch_count_4), 64'hF);
    check("bc4_saturated", 64'(bubble_count_4), 64'hF);

    // Asynchronous reset mid-cycle: outputs clear before the next edge
    #2;
    rst = 1'b0;
    #1;
    check("arst_imem_addr", imem_addr, 64'd0);
    check("arst_id_valid", 64'(id_valid), 64'd0);
    check("arst_id_instr", 64'(id_instruction), 64'(NOP));
    check("arst_id_pc4", id_pc_plus4, 64'd0);
    check("arst_misalign", 64'(misalign_err), 64'd0);
    check("arst_fetch_count", 64'(fetch_count), 64'd0);
    check("arst_bubble_count", 64'(bubble_count), 64'd0);
    check("arst_fsm_boot", 64'(fsm_state), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(3);
    check("post_arst_id_pc", id_pc, 64'd4);
    check("post_arst_fc", 64'(fetch_count), 64'd2);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined CPU: owns the PC register, drives the instruction-memory address, and captures fetched words into the IF/ID pipeline register for decode.
- Accepts stall and flush requests from the hazard unit and branch redirects resolved downstream.
- Keeps saturating fetch and bubble counters for performance debug.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INSTR, 32'hD503201F, encoding inserted into IF/ID as a bubble.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- stall_if  input  1  hold PC and IF/ID contents this cycle.
- flush_id  input  1  replace the IF/ID contents with a bubble this cycle.
- redirect_valid  input  1  branch resolved taken; load redirect_pc.
- redirect_pc  input  64  branch/BR target.
- halt_req  input  1  stop fetching.
- imem_addr  output  64  current PC to instruction memory (combinational read).
- imem_instr  input  32  instruction at imem_addr, same cycle.
- id_valid  output  1  IF/ID holds a real instruction.
- id_pc  output  64  PC of the IF/ID instruction.
- id_pc_plus4  output  64  id_pc+4, used for BL link.
- id_instruction  output  32  instruction to decode.
- misalign_err  output  1  sticky: a redirect target had bits[1:0] != 0.
- fetch_count  output  CNT_W  valid instructions captured into IF/ID.
- bubble_count  output  CNT_W  bubbles inserted into IF/ID.

Behaviour:
- Reset (rst low, asynchronous):
  - pc = RESET_PC.
  - id_valid = 0, id_pc = 0, id_pc_plus4 = 0, id_instruction = NOP_INSTR.
  - misalign_err = 0, both counters = 0.
  - State = BOOT.
  - Reset asserted mid-operation discards any in-flight fetch with no partial update.
- imem_addr = pc at all times (combinational).
- FSM states: BOOT, RUN, HALT.
- BOOT:
  - Lasts exactly one cycle after rst deasserts.
  - IF/ID loads a bubble; bubble_count is not incremented.
  - pc does not advance.
  - Goes to RUN unconditionally.
- RUN, evaluated each cycle in this priority order:
  1. redirect_valid: pc <= {redirect_pc[63:2], 2'b00}. IF/ID gets a bubble; bubble_count++. If redirect_pc[1:0] != 0, set misalign_err. Redirect beats stall and halt_req in the same cycle.
  2. halt_req: IF/ID gets a bubble, bubble_count++, pc holds, go to HALT.
  3. stall_if: pc and all IF/ID outputs hold; counters hold. flush_id in the same cycle is ignored (stall wins).
  4. flush_id: IF/ID gets a bubble; bubble_count++; pc <= pc+4.
  5. Otherwise: IF/ID <= {valid=1, pc, pc+4, imem_instr}; fetch_count++; pc <= pc+4.
- HALT:
  - pc holds. IF/ID gets a bubble each cycle; bubble_count does not increment while in HALT.
  - Leaves only on redirect_valid: same actions as RUN case 1, next state RUN.
  - stall_if, flush_id and halt_req are ignored in HALT.
- Bubble means id_valid = 0, id_instruction = NOP_INSTR, id_pc = 0, id_pc_plus4 = 0.
- Arithmetic:
  - pc+4 is 64-bit modulo; it wraps at 2^64 silently.
  - Counters saturate at all-ones and never wrap.
- misalign_err clears only on reset.
- Latency: the instruction at PC X appears on the id_* outputs on the rising edge that ends the cycle in which imem_addr = X (one cycle).

Test Plan:
- Reset release, imem returns 32'h91000421 at addr 0 and 32'h8B020020 at addr 4 → cycle 1 is a bubble (BOOT); cycle 2 id_pc=0, id_instruction=91000421, id_valid=1; cycle 3 id_pc=4; fetch_count=2, bubble_count=0.
- stall_if held 3 cycles with pc=8 → imem_addr stays 8 and id_* stay frozen; after release id_pc=8, fetch_count increments by 1 only.
- redirect_valid with redirect_pc=64'h40 and stall_if=1 in the same cycle → next cycle imem_addr=0x40 and id_valid=0; following cycle id_pc=0x40; bubble_count+1.
- redirect_pc=64'h43 → pc=0x40 and misalign_err=1, still 1 after 10 cycles; it clears only when rst is pulsed low asynchronously mid-cycle (outputs reset immediately, before the next edge).
- halt_req at pc=0x10 → id_valid=0 every cycle and imem_addr held at 0x10 for 20 cycles with bubble_count +1 total; then redirect to 0x0 → RUN resumes and id_pc=0 one cycle later.
- Preload pc near 64'hFFFF_FFFF_FFFF_FFFC via redirect, run 2 cycles → imem_addr wraps to 0; force fetch_count to all-ones (CNT_W=4 build) → it stays 4'hF.
